// File: rtl/async_down_counter_nbit.sv
// n-bit ripple down counter built from a chain of toggle flops with async all-ones preset.
// Optional combinational zero flag when COUNTER_ZERO_FLAG_EN is defined.
module async_down_counter_nbit #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         preset_n,
  output logic [n-1:0] Q
`ifdef COUNTER_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int unsigned W = n;

  // Each stage toggles on the rising edge of its predecessor; a 0->1 ripple yields a decrement.
  for (genvar i = 0; i < int'(W); i++) begin : g_stage
    logic stage_q;
    logic stage_clk;

    if (i == 0) begin : g_first
      assign stage_clk = clk;
    end else begin : g_chain
      assign stage_clk = Q[i-1];
    end

    always_ff @(posedge stage_clk or negedge preset_n) begin
      if (!preset_n) begin
        stage_q <= 1'b1;
      end else begin
        stage_q <= ~stage_q;
      end
    end

    assign Q[i] = stage_q;
  end

`ifdef COUNTER_ZERO_FLAG_EN
  // Decoded from the stage outputs; may glitch while the chain ripples.
  assign zero = (Q == W'(0));
`endif

endmodule

// File: tb/tb_async_down_counter_nbit.sv
// Scoreboard bench for async_down_counter_nbit: n=4 main instance plus n=1 and n=8 width instances.
// Zero flag checks are active when COUNTER_ZERO_FLAG_EN is defined.
module tb_async_down_counter_nbit;

  logic       clk;
  logic       preset4_n, preset1_n, preset8_n;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;
`ifdef COUNTER_ZERO_FLAG_EN
  logic       zero4, zero1, zero8;
`endif

  int checks;
  int failures;
  int edges;

  typedef struct {
    logic [3:0] q4;
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m4;
  logic       m1;
  logic [7:0] m8;

  async_down_counter_nbit #(.n(4)) u_dut4 (
    .clk(clk), .preset_n(preset4_n), .Q(q4)
`ifdef COUNTER_ZERO_FLAG_EN
    , .zero(zero4)
`endif
  );

  async_down_counter_nbit #(.n(1)) u_dut1 (
    .clk(clk), .preset_n(preset1_n), .Q(q1)
`ifdef COUNTER_ZERO_FLAG_EN
    , .zero(zero1)
`endif
  );

  async_down_counter_nbit #(.n(8)) u_dut8 (
    .clk(clk), .preset_n(preset8_n), .Q(q8)
`ifdef COUNTER_ZERO_FLAG_EN
    , .zero(zero8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clk rising edge: advance the models, queue the expectation, wait for the settle point.
  task automatic step();
    @(posedge clk);
    m4 = m4 - 4'd1;
    m1 = ~m1;
    m8 = m8 - 8'd1;
    edges++;
    sb.push_back('{q4: m4, q1: m1, q8: m8});
    @(negedge clk);
  endtask

  task automatic test_reset();
    preset4_n = 1'b1; preset1_n = 1'b1; preset8_n = 1'b1;
    #1;
    preset4_n = 1'b0; preset1_n = 1'b0; preset8_n = 1'b0;
    m4 = 4'hF; m1 = 1'b1; m8 = 8'hFF;
    #2;
    checks++;
    if (q4 !== 4'hF) begin failures++; $display("FAIL reset_async_q4 got=%h exp=%h", q4, 4'hF); end
    #5; // t=8: the edge at 5 ns must have been ignored
    checks++;
    if (q4 !== 4'hF) begin failures++; $display("FAIL reset_edge_ignored_q4 got=%h exp=%h", q4, 4'hF); end
    checks++;
    if (q1 !== 1'b1) begin failures++; $display("FAIL reset_q1 got=%b exp=1", q1); end
    checks++;
    if (q8 !== 8'hFF) begin failures++; $display("FAIL reset_q8 got=%h exp=ff", q8); end
`ifdef COUNTER_ZERO_FLAG_EN
    checks++;
    if (zero4 !== 1'b0) begin failures++; $display("FAIL reset_zero4 got=%b exp=0", zero4); end
`endif
    #5; // t=13
    preset4_n = 1'b1; preset1_n = 1'b1; preset8_n = 1'b1;
    checks++;
    if (q4 !== 4'hF) begin failures++; $display("FAIL release_q4 got=%h exp=f", q4); end
  endtask

  task automatic test_first_count();
    exp_t e;
    step();
    e = sb.pop_front();
    checks++;
    if (q4 !== e.q4 || q4 !== 4'hE) begin failures++; $display("FAIL first_edge_q4 got=%h exp=%h", q4, e.q4); end
    step();
    e = sb.pop_front();
    checks++;
    if (q4 !== e.q4 || q4 !== 4'hD) begin failures++; $display("FAIL second_edge_q4 got=%h exp=%h", q4, e.q4); end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int k = 0; k < 18; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (q4 !== e.q4) begin failures++; $display("FAIL wrap_seq_q4 edge=%0d got=%h exp=%h", edges, q4, e.q4); end
`ifdef COUNTER_ZERO_FLAG_EN
      checks++;
      if (zero4 !== (e.q4 == 4'h0)) begin
        failures++; $display("FAIL wrap_zero4 edge=%0d got=%b exp=%b", edges, zero4, (e.q4 == 4'h0));
      end
`endif
      if (edges == 15) begin
        checks++;
        if (q4 !== 4'h0) begin failures++; $display("FAIL wrap_reach_zero got=%h exp=0", q4); end
      end
      if (edges == 16) begin
        checks++;
        if (q4 !== 4'hF) begin failures++; $display("FAIL wrap_to_f got=%h exp=f", q4); end
      end
    end
  endtask

  task automatic test_midcount_preset();
    exp_t e;
    while (m4 != 4'h6) begin
      step();
      e = sb.pop_front();
      checks++;
      if (q4 !== e.q4) begin failures++; $display("FAIL pre_pulse_q4 got=%h exp=%h", q4, e.q4); end
    end
    #1;
    preset4_n = 1'b0;
    m4 = 4'hF;
    #1;
    checks++;
    if (q4 !== 4'hF) begin failures++; $display("FAIL midcount_preset_q4 got=%h exp=f", q4); end
`ifdef COUNTER_ZERO_FLAG_EN
    checks++;
    if (zero4 !== 1'b0) begin failures++; $display("FAIL midcount_zero4 got=%b exp=0", zero4); end
`endif
    #2;
    preset4_n = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if (q4 !== e.q4 || q4 !== 4'hE) begin failures++; $display("FAIL post_pulse_q4 got=%h exp=%h", q4, e.q4); end
  endtask

  task automatic test_width();
    exp_t e;
    while (edges < 257) begin
      step();
      e = sb.pop_front();
      checks++;
      if (q1 !== e.q1) begin failures++; $display("FAIL width1_q1 edge=%0d got=%b exp=%b", edges, q1, e.q1); end
      checks++;
      if (q8 !== e.q8) begin failures++; $display("FAIL width8_q8 edge=%0d got=%h exp=%h", edges, q8, e.q8); end
`ifdef COUNTER_ZERO_FLAG_EN
      checks++;
      if (zero8 !== (e.q8 == 8'h00)) begin
        failures++; $display("FAIL width8_zero edge=%0d got=%b exp=%b", edges, zero8, (e.q8 == 8'h00));
      end
      checks++;
      if (zero1 !== (e.q1 == 1'b0)) begin
        failures++; $display("FAIL width1_zero edge=%0d got=%b exp=%b", edges, zero1, (e.q1 == 1'b0));
      end
`endif
      if (edges == 255) begin
        checks++;
        if (q8 !== 8'h00) begin failures++; $display("FAIL width8_at_255 got=%h exp=00", q8); end
      end
      if (edges == 256) begin
        checks++;
        if (q8 !== 8'hFF) begin failures++; $display("FAIL width8_at_256 got=%h exp=ff", q8); end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    test_reset();
    test_first_count();
    test_wrap();
    test_midcount_preset();
    test_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
